// File: rtl/seg7_snoop.sv
// seg7_snoop: reads the multiplexed active-low 7-segment bus back into per-position digit codes.
// Defining SEG7_SNOOP_ERR_EN builds the sticky error logic; otherwise err is tied low.
module seg7_snoop #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [DIGITS-1:0]   an,
    input  logic                err_clr,
    output logic [4*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]   blank,
    output logic                frame_valid,
    output logic                err
);
    localparam int                IDXW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0]        STABLE_CNT = 4'(STABLE);
    localparam logic [DIGITS-1:0] ALL_SEEN   = {DIGITS{1'b1}};

    logic [6:0]        seg_q_reg;
    logic [DIGITS-1:0] an_q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q_reg <= 7'h7F;
            an_q_reg  <= '1;
        end else begin
            seg_q_reg <= seg;
            an_q_reg  <= an;
        end
    end

    // Pattern decode; anything not in the table is reported as code E.
    logic [3:0] code;
    always_comb begin
        case (seg_q_reg)
            7'h40:   code = 4'h0;
            7'h79:   code = 4'h1;
            7'h24:   code = 4'h2;
            7'h30:   code = 4'h3;
            7'h19:   code = 4'h4;
            7'h12:   code = 4'h5;
            7'h02:   code = 4'h6;
            7'h78:   code = 4'h7;
            7'h00:   code = 4'h8;
            7'h10:   code = 4'h9;
            7'h7F:   code = 4'hF;
            default: code = 4'hE;
        endcase
    end

    logic [3:0]      low_cnt;
    logic [IDXW-1:0] strobe_idx;
    logic            strobe_valid;
    logic            strobe_multi;

    always_comb begin
        low_cnt    = '0;
        strobe_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q_reg[i]) begin
                low_cnt    = low_cnt + 4'd1;
                strobe_idx = IDXW'(i);
            end
        end
        strobe_valid = (low_cnt == 4'd1);
        strobe_multi = (low_cnt > 4'd1);
    end

    logic [IDXW-1:0] cand_idx_reg, cand_idx_next;
    logic [3:0]      cand_code_reg, cand_code_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic            done_reg, done_next;
    logic            commit;

    // done holds off further commits until the dwell ends, so each dwell commits once.
    always_comb begin
        cand_idx_next  = cand_idx_reg;
        cand_code_next = cand_code_reg;
        cnt_next       = cnt_reg;
        done_next      = done_reg;
        commit         = 1'b0;
        if (!strobe_valid) begin
            cnt_next  = '0;
            done_next = 1'b0;
        end else begin
            if (strobe_idx == cand_idx_reg && code == cand_code_reg) begin
                if (cnt_reg < STABLE_CNT)
                    cnt_next = cnt_reg + 4'd1;
            end else begin
                cand_idx_next  = strobe_idx;
                cand_code_next = code;
                cnt_next       = 4'd1;
                done_next      = 1'b0;
            end
            commit = (cnt_next == STABLE_CNT) && !done_next;
            if (commit)
                done_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_idx_reg  <= '0;
            cand_code_reg <= 4'hF;
            cnt_reg       <= '0;
            done_reg      <= 1'b0;
        end else begin
            cand_idx_reg  <= cand_idx_next;
            cand_code_reg <= cand_code_next;
            cnt_reg       <= cnt_next;
            done_reg      <= done_next;
        end
    end

    logic [DIGITS-1:0] commit_vec;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_pos
            logic [3:0] digit_reg;
            logic       blank_reg;

            assign commit_vec[gi] = commit && (strobe_idx == IDXW'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    digit_reg <= 4'hF;
                    blank_reg <= 1'b1;
                end else if (commit_vec[gi]) begin
                    digit_reg <= code;
                    blank_reg <= (code == 4'hF);
                end
            end

            assign digits[4*gi +: 4] = digit_reg;
            assign blank[gi]         = blank_reg;
        end
    endgenerate

    logic [DIGITS-1:0] seen_reg, seen_next;
    logic              frame_valid_reg;

    // A full seen vector is held for one cycle: that cycle emits the pulse and starts a new frame.
    always_comb begin
        if (seen_reg == ALL_SEEN)
            seen_next = commit_vec;
        else
            seen_next = seen_reg | commit_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_reg        <= '0;
            frame_valid_reg <= 1'b0;
        end else begin
            seen_reg        <= seen_next;
            frame_valid_reg <= (seen_reg == ALL_SEEN);
        end
    end

    assign frame_valid = frame_valid_reg;

`ifdef SEG7_SNOOP_ERR_EN
    logic err_reg;
    logic err_set;

    assign err_set = (commit && code == 4'hE) || strobe_multi;

    // A set event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)
            err_reg <= 1'b0;
        else if (err_set)
            err_reg <= 1'b1;
        else if (err_clr)
            err_reg <= 1'b0;
    end

    assign err = err_reg;
`else
    logic unused_err_inputs;
    assign unused_err_inputs = err_clr ^ strobe_multi;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_snoop.sv
// Testbench for seg7_snoop: directed steps plus random dwells, checked every cycle against a
// sample-history reference model of the bus decoding.
module tb_seg7_snoop;
    localparam int DIGITS = 4;
    localparam int STABLE = 3;
`ifdef SEG7_SNOOP_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif
    localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic                clk = 1'b0;
    logic                rst;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                err_clr;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   blank;
    logic                frame_valid;
    logic                err;

    seg7_snoop #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .err_clr     (err_clr),
        .digits      (digits),
        .blank       (blank),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fv_count;

    // Reference model: history of the last STABLE+1 decoded samples (key -1 = idle or multi-hot).
    int                  hist[$];
    logic [4*DIGITS-1:0] m_digits;
    logic [DIGITS-1:0]   m_blank;
    logic [DIGITS-1:0]   m_seen;
    logic                m_pend;
    logic                m_fv;
    logic                m_err;
    logic [6:0]          prev_seg;
    logic [DIGITS-1:0]   prev_an;

    function automatic int decode(logic [6:0] p);
        if (p == 7'h7F) return 15;
        for (int i = 0; i < 10; i++)
            if (PAT[i] == p) return i;
        return 14;
    endfunction

    function automatic int lows(logic [DIGITS-1:0] a);
        int n = 0;
        for (int i = 0; i < DIGITS; i++)
            if (!a[i]) n++;
        return n;
    endfunction

    function automatic int skey(logic [6:0] s, logic [DIGITS-1:0] a);
        int idx = 0;
        if (lows(a) != 1) return -1;
        for (int i = 0; i < DIGITS; i++)
            if (!a[i]) idx = i;
        return idx * 16 + decode(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int i = 0; i <= STABLE; i++) hist.push_back(-1);
        m_digits = '1;
        m_blank  = '1;
        m_seen   = '0;
        m_pend   = 1'b0;
        m_fv     = 1'b0;
        m_err    = 1'b0;
        prev_seg = 7'h7F;
        prev_an  = '1;
    endtask

    // Outputs after the coming edge reflect the sample registered at the previous edge.
    task automatic model_advance(input logic clr);
        int  k;
        bit  commit;
        bit  set;
        int  idx;
        int  code;
        k = skey(prev_seg, prev_an);
        hist.push_back(k);
        void'(hist.pop_front());
        commit = (k >= 0) && (hist[0] != k);
        for (int i = 1; i <= STABLE; i++)
            if (hist[i] != k) commit = 1'b0;
        m_fv = m_pend;
        if (m_pend) begin
            m_seen = '0;
            m_pend = 1'b0;
        end
        idx  = (k >= 0) ? k / 16 : 0;
        code = (k >= 0) ? k % 16 : 0;
        if (commit) begin
            m_digits[4*idx +: 4] = 4'(code);
            m_blank[idx]         = (code == 15);
            m_seen[idx]          = 1'b1;
            if (m_seen == '1) m_pend = 1'b1;
        end
        set = (lows(prev_an) > 1) || (commit && code == 14);
        if (ERR_ON) m_err = set ? 1'b1 : (clr ? 1'b0 : m_err);
        else        m_err = 1'b0;
    endtask

    task automatic step(input logic [6:0] s, input logic [DIGITS-1:0] a, input logic c, input logic r);
        seg     = s;
        an      = a;
        err_clr = c;
        rst     = r;
        if (r) model_reset();
        else   model_advance(c);
        @(posedge clk);
        #1;
        chk("digits", 32'(digits), 32'(m_digits));
        chk("blank", 32'(blank), 32'(m_blank));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("err", 32'(err), 32'(m_err));
        if (frame_valid === 1'b1) fv_count++;
        if (!r) begin
            prev_seg = s;
            prev_an  = a;
        end
    endtask

    task automatic dwell(input logic [6:0] s, input logic [DIGITS-1:0] a, input int n);
        for (int i = 0; i < n; i++) step(s, a, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0]        rs;
        logic [DIGITS-1:0] ra;
        int                kind;
        int                len;
        int                p0;
        int                p1;

        fv_count = 0;
        model_reset();
        // Reset with arbitrary bus contents
        step(7'($urandom), DIGITS'($urandom), 1'b1, 1'b1);
        step(7'($urandom), DIGITS'($urandom), 1'b0, 1'b1);
        chk("rst_digits", 32'(digits), 32'h0000FFFF);
        chk("rst_blank", 32'(blank), 32'hF);

        // Full frame 0,1,2,3
        fv_count = 0;
        dwell(7'h40, 4'b1110, 5);
        dwell(7'h79, 4'b1101, 5);
        dwell(7'h24, 4'b1011, 5);
        dwell(7'h30, 4'b0111, 5);
        dwell(7'h7F, 4'b1111, 2);
        chk("frame_digits", 32'(digits), 32'h00003210);
        chk("frame_blank", 32'(blank), 32'h0);
        chk("frame_pulses", 32'(fv_count), 32'd1);

        // Reset mid-frame discards the partial frame
        dwell(7'h00, 4'b1110, 4);
        dwell(7'h10, 4'b1101, 4);
        step(7'h40, 4'b1110, 1'b0, 1'b1);
        fv_count = 0;
        dwell(7'h02, 4'b1011, 4);
        dwell(7'h78, 4'b0111, 4);
        dwell(7'h7F, 4'b1111, 2);
        chk("partial_no_frame", 32'(fv_count), 32'd0);
        dwell(7'h12, 4'b1110, 4);
        dwell(7'h19, 4'b1101, 4);
        dwell(7'h7F, 4'b1111, 2);
        chk("post_rst_frame", 32'(fv_count), 32'd1);
        chk("post_rst_digits", 32'(digits), 32'h00007645);

        // Glitch: short dwell of 4, then 5
        dwell(7'h19, 4'b1110, 2);
        dwell(7'h12, 4'b1110, 4);
        dwell(7'h7F, 4'b1111, 1);
        chk("glitch_digit0", 32'(digits[3:0]), 32'h5);

        // Blank and invalid
        dwell(7'h7F, 4'b1101, 4);
        dwell(7'h7F, 4'b1111, 1);
        chk("blank1", 32'(blank[1]), 32'd1);
        chk("blank1_digit", 32'(digits[7:4]), 32'hF);
        dwell(7'h55, 4'b1011, 4);
        dwell(7'h7F, 4'b1111, 1);
        chk("invalid_digit2", 32'(digits[11:8]), 32'hE);
        chk("invalid_err", 32'(err), 32'(ERR_ON));
        step(7'h7F, 4'b1111, 1'b1, 1'b0);
        chk("err_cleared", 32'(err), 32'd0);

        // Multi-hot strobe
        dwell(7'h40, 4'b1100, 6);
        dwell(7'h7F, 4'b1111, 1);
        chk("multihot_err", 32'(err), 32'(ERR_ON));
        chk("multihot_digits", 32'(digits), 32'(m_digits));
        step(7'h7F, 4'b1111, 1'b1, 1'b0);

        // Randomized dwells
        for (int it = 0; it < 300; it++) begin
            kind = int'($urandom_range(0, 19));
            len  = int'($urandom_range(1, 6));
            if (kind < 15) begin
                p0 = int'($urandom_range(0, 11));
                if (p0 < 10)       rs = PAT[p0];
                else if (p0 == 10) rs = 7'h7F;
                else               rs = 7'($urandom);
                ra = '1;
                ra[$urandom_range(0, DIGITS-1)] = 1'b0;
            end else if (kind < 17) begin
                rs = 7'($urandom);
                ra = '1;
            end else if (kind < 19) begin
                rs = PAT[$urandom_range(0, 9)];
                p0 = int'($urandom_range(0, DIGITS-1));
                p1 = (p0 + int'($urandom_range(1, DIGITS-1))) % DIGITS;
                ra = DIGITS'($urandom);
                ra[p0] = 1'b0;
                ra[p1] = 1'b0;
            end else begin
                rs = 7'($urandom);
                ra = DIGITS'($urandom);
                len = 1;
            end
            for (int i = 0; i < len; i++)
                step(rs, ra, ($urandom_range(0, 7) == 0), (kind == 19));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
